// File: rtl/core_pkg.sv
// Shared types and constants for the core front end.
package core_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned FIFO_DEPTH = 2;
    localparam logic [XLEN-1:0] NOP    = 32'h0000_0013;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo2.sv
// Two-entry fetch FIFO: head/tail registers, head always presented to decode.
module fetch_fifo2
    import core_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic         flush_i,
    input  fetch_entry_t wdata_i,
    output fetch_entry_t head_o,
    output logic         valid_o,
    output logic [1:0]   count_o
);

    fetch_entry_t head_q, head_d;
    fetch_entry_t tail_q, tail_d;
    logic [1:0]   count_q, count_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Pop shifts tail into head; simultaneous push refills the freed slot.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_i) begin
            count_d = 2'd0;
        end else begin
            case ({push_i, pop_i})
                2'b10: begin
                    if (count_q == 2'd0) head_d = wdata_i;
                    else                 tail_d = wdata_i;
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    head_d  = tail_q;
                    count_d = count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd2) begin
                        head_d = tail_q;
                        tail_d = wdata_i;
                    end else begin
                        head_d = wdata_i;
                    end
                end
                default: ;
            endcase
        end
    end

    assign head_o  = head_q;
    assign valid_o = (count_q != 2'd0);
    assign count_o = count_q;

endmodule

// File: rtl/im_fetch_ctrl.sv
// Instruction-fetch sequencer: PC, run/halt control, redirect flush and
// delivery counter in front of a 2-entry fetch FIFO.
module im_fetch_ctrl
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic [31:0] im_addr_o,
    input  logic [31:0] im_data_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        halt_i,
    input  logic        resume_i,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic        misalign_o,
    output logic [31:0] fetch_cnt_o
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  cnt_q, cnt_d;
    logic         misalign_q, misalign_d;

    logic         push, pop, head_valid;
    logic [1:0]   count;
    fetch_entry_t wentry, head;

    assign pop  = head_valid && ready_i;
    assign push = (state_q == RUN) && !redirect_i && !halt_i &&
                  ((count < 2'(FIFO_DEPTH)) || pop);

    assign wentry.pc    = pc_q;
    assign wentry.instr = im_data_i;

    fetch_fifo2 u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (redirect_i),
        .wdata_i (wentry),
        .head_o  (head),
        .valid_o (head_valid),
        .count_o (count)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= RUN;
            pc_q       <= {RESET_PC[31:2], 2'b00};
            cnt_q      <= 32'd0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            cnt_q      <= cnt_d;
            misalign_q <= misalign_d;
        end
    end

    // Redirect never changes run/halt state; halt beats a simultaneous resume.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        cnt_d      = cnt_q + 32'(pop);
        misalign_d = misalign_q;

        case (state_q)
            RUN:     if (halt_i) state_d = HALT;
            HALT:    if (resume_i && !halt_i) state_d = RUN;
            default: state_d = RUN;
        endcase

        if (redirect_i) begin
            pc_d = {redirect_pc_i[31:2], 2'b00};
            if (redirect_pc_i[1:0] != 2'b00) misalign_d = 1'b1;
        end else if (push) begin
            pc_d = pc_q + 32'd4;
        end
    end

    assign im_addr_o   = {2'b00, pc_q[31:2]};
    assign valid_o     = head_valid;
    assign instr_o     = head.instr;
    assign pc_o        = head.pc;
    assign misalign_o  = misalign_q;
    assign fetch_cnt_o = cnt_q;

endmodule
